// File: rtl/btn_debounce_multi_pkg.sv
// rtl/btn_debounce_multi_pkg.sv - btn_pkg: default timing constants, channel limit and counter width helper
package btn_pkg;

  localparam int unsigned MAX_N_CH              = 16;
  localparam int unsigned DEF_N_CH              = 4;
  localparam int unsigned DEF_SETTLE_CYCLES     = 500000;
  localparam int unsigned DEF_REPEAT_DELAY      = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD     = 5000000;

  // Bits needed to hold every value 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// rtl/btn_debounce_multi_if.sv - button bundle: raw inputs plus debounced level, pulses and toggle state
interface btn_debounce_multi_if #(
  parameter int unsigned N_CH = 4
);

  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_toggle;
  logic            any_press;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_toggle,
    input  any_press
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_toggle,
    output any_press
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, settle counter, edge pulses, toggle
// Auto-repeat press pulses are built only when BTN_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  btn_debounce_multi_if.slave   ch_if
);

  localparam int unsigned         CW          = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0]       SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          level_d_q;
  logic          press_q;
  logic          release_q;
  logic          toggle_q;
  logic          rise;
  logic          fall;
  logic          rpt_hit;

  assign rise = level_q & ~level_d_q;
  assign fall = ~level_q & level_d_q;

  // The counter compares against SETTLE_CYCLES-1 because the clearing edge is
  // the one on which it would have reached SETTLE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      sync_q1   <= ch_if.btn_in[0];
      sync_q2   <= sync_q1;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == SETTLE_LAST) begin
        cnt_q   <= '0;
        level_q <= ~level_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      level_d_q <= level_q;
      press_q   <= rise | rpt_hit;
      release_q <= fall;
      toggle_q  <= toggle_q ^ rise;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned   RW       = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] DELAY_V  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] PERIOD_V = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rpt_q;
  logic          rpt_phase_q;
  logic [RW-1:0] rpt_next;
  logic [RW-1:0] rpt_target;

  always_comb begin
    rpt_next   = rpt_q + RW'(1);
    rpt_target = rpt_phase_q ? PERIOD_V : DELAY_V;
  end

  // Counts edges since the last press pulse; phase 0 waits the initial delay,
  // phase 1 the repeat period.
  assign rpt_hit = level_q & level_d_q & (rpt_next == rpt_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
    end else if (!level_q || rise) begin
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
    end else if (rpt_hit) begin
      rpt_q       <= '0;
      rpt_phase_q <= 1'b1;
    end else begin
      rpt_q <= rpt_next;
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

  assign ch_if.btn_level[0]   = level_q;
  assign ch_if.btn_press[0]   = press_q;
  assign ch_if.btn_release[0] = release_q;
  assign ch_if.btn_toggle[0]  = toggle_q;
  assign ch_if.any_press      = press_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N_CH independent debounced buttons with press/release pulses and toggle
// Optional auto-repeat on btn_press is enabled by defining BTN_REPEAT_EN.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_CH          = DEF_N_CH,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_toggle,
  output logic            any_press
);

  logic [N_CH-1:0] ch_any;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_multi_if #(.N_CH(1)) ch_if ();

    assign ch_if.btn_in[0] = btn_in[i];
    assign btn_level[i]    = ch_if.btn_level[0];
    assign btn_press[i]    = ch_if.btn_press[0];
    assign btn_release[i]  = ch_if.btn_release[0];
    assign btn_toggle[i]   = ch_if.btn_toggle[0];
    assign ch_any[i]       = ch_if.any_press;

    btn_debounce_ch #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .ch_if (ch_if.slave)
    );
  end

  assign any_press = |ch_any;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - directed self-checking bench for btn_debounce_multi
module tb_btn_debounce_multi;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  btn_debounce_multi_if #(.N_CH(4)) bus ();

  btn_debounce_multi #(
    .N_CH          (4),
    .SETTLE_CYCLES (8),
    .REPEAT_DELAY  (40),
    .REPEAT_PERIOD (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (bus.btn_in),
    .btn_level   (bus.btn_level),
    .btn_press   (bus.btn_press),
    .btn_release (bus.btn_release),
    .btn_toggle  (bus.btn_toggle),
    .any_press   (bus.any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.btn_in = 4'b0000;
    #1;
    total++; if (bus.btn_level !== 4'b0000) begin bad++; $display("FAIL reset_level got=%b exp=0000", bus.btn_level); end
    tick(2);
    total++; if (bus.btn_press !== 4'b0000) begin bad++; $display("FAIL reset_press got=%b exp=0000", bus.btn_press); end
    total++; if (bus.btn_toggle !== 4'b0000) begin bad++; $display("FAIL reset_toggle got=%b exp=0000", bus.btn_toggle); end
    total++; if (bus.any_press !== 1'b0) begin bad++; $display("FAIL reset_any got=%b exp=0", bus.any_press); end
    rst_n = 1'b1;
    tick(3);
    total++; if (bus.btn_release !== 4'b0000) begin bad++; $display("FAIL idle_release got=%b exp=0000", bus.btn_release); end
  endtask

  task automatic test_clean_press;
    bus.btn_in[0] = 1'b1;
    tick(9);
    total++; if (bus.btn_level !== 4'b0000) begin bad++; $display("FAIL press_level_early got=%b exp=0000", bus.btn_level); end
    tick(1);
    total++; if (bus.btn_level !== 4'b0001) begin bad++; $display("FAIL press_level_10 got=%b exp=0001", bus.btn_level); end
    total++; if (bus.btn_press !== 4'b0000) begin bad++; $display("FAIL press_early_pulse got=%b exp=0000", bus.btn_press); end
    tick(1);
    total++; if (bus.btn_press !== 4'b0001) begin bad++; $display("FAIL press_pulse got=%b exp=0001", bus.btn_press); end
    total++; if (bus.any_press !== 1'b1) begin bad++; $display("FAIL press_any got=%b exp=1", bus.any_press); end
    total++; if (bus.btn_toggle !== 4'b0001) begin bad++; $display("FAIL press_toggle got=%b exp=0001", bus.btn_toggle); end
    tick(1);
    total++; if ({bus.any_press, bus.btn_press} !== 5'b0) begin bad++; $display("FAIL press_one_cycle got=%b exp=00000", {bus.any_press, bus.btn_press}); end
    bus.btn_in[0] = 1'b0;
    tick(10);
    total++; if (bus.btn_level !== 4'b0000) begin bad++; $display("FAIL release_level got=%b exp=0000", bus.btn_level); end
    tick(1);
    total++; if (bus.btn_release !== 4'b0001) begin bad++; $display("FAIL release_pulse got=%b exp=0001", bus.btn_release); end
    tick(1);
    total++; if (bus.btn_release !== 4'b0000) begin bad++; $display("FAIL release_one_cycle got=%b exp=0000", bus.btn_release); end
    total++; if (bus.btn_toggle !== 4'b0001) begin bad++; $display("FAIL release_toggle got=%b exp=0001", bus.btn_toggle); end
  endtask

  task automatic test_bounce;
    logic seen;
    seen = 1'b0;
    for (int seg = 0; seg < 10; seg++) begin
      bus.btn_in[1] = (seg % 2 == 0);
      repeat (3) begin
        @(negedge clk);
        if (bus.btn_press !== 4'b0000 || bus.btn_level[1] !== 1'b0) seen = 1'b1;
      end
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL bounce_quiet got=%b exp=0", seen); end
    bus.btn_in[1] = 1'b1;
    tick(9);
    total++; if (bus.btn_level[1] !== 1'b0) begin bad++; $display("FAIL bounce_level_early got=%b exp=0", bus.btn_level[1]); end
    tick(1);
    total++; if (bus.btn_level[1] !== 1'b1) begin bad++; $display("FAIL bounce_level got=%b exp=1", bus.btn_level[1]); end
    tick(1);
    total++; if (bus.btn_press !== 4'b0010) begin bad++; $display("FAIL bounce_press got=%b exp=0010", bus.btn_press); end
    bus.btn_in[1] = 1'b0;
    tick(14);
    total++; if (bus.btn_toggle !== 4'b0011) begin bad++; $display("FAIL bounce_toggle got=%b exp=0011", bus.btn_toggle); end
  endtask

  task automatic test_glitch;
    logic seen;
    seen = 1'b0;
    bus.btn_in[2] = 1'b1;
    tick(7);
    bus.btn_in[2] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.btn_level[2] | bus.btn_press[2] | bus.btn_release[2] | bus.btn_toggle[2] | bus.any_press)
        seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL glitch_outputs got=%b exp=0", seen); end
  endtask

  task automatic test_simultaneous;
    bus.btn_in = 4'b1111;
    tick(11);
    total++; if (bus.btn_press !== 4'b1111) begin bad++; $display("FAIL simul_press got=%b exp=1111", bus.btn_press); end
    total++; if (bus.btn_toggle !== 4'b1100) begin bad++; $display("FAIL simul_toggle got=%b exp=1100", bus.btn_toggle); end
    tick(1);
    total++; if (bus.btn_press !== 4'b0000) begin bad++; $display("FAIL simul_press_end got=%b exp=0000", bus.btn_press); end
    bus.btn_in = 4'b0000;
    tick(11);
    total++; if (bus.btn_release !== 4'b1111) begin bad++; $display("FAIL simul_release got=%b exp=1111", bus.btn_release); end
    total++; if (bus.btn_toggle !== 4'b1100) begin bad++; $display("FAIL simul_release_toggle got=%b exp=1100", bus.btn_toggle); end
    tick(3);
  endtask

  task automatic test_reset_mid_settle;
    bus.btn_in = 4'b1000;
    tick(12);
    total++; if ({bus.btn_level, bus.btn_toggle} !== 8'b1000_0100) begin bad++; $display("FAIL pre_reset_state got=%b exp=10000100", {bus.btn_level, bus.btn_toggle}); end
    bus.btn_in = 4'b1001;
    tick(7);
    rst_n = 1'b0;
    #1;
    total++; if (bus.btn_level !== 4'b0000) begin bad++; $display("FAIL mid_reset_level got=%b exp=0000", bus.btn_level); end
    total++; if (bus.btn_toggle !== 4'b0000) begin bad++; $display("FAIL mid_reset_toggle got=%b exp=0000", bus.btn_toggle); end
    tick(2);
    rst_n = 1'b1;
    tick(9);
    total++; if (bus.btn_level !== 4'b0000) begin bad++; $display("FAIL post_reset_early got=%b exp=0000", bus.btn_level); end
    tick(1);
    total++; if (bus.btn_level !== 4'b1001) begin bad++; $display("FAIL post_reset_level got=%b exp=1001", bus.btn_level); end
    tick(1);
    total++; if (bus.btn_press !== 4'b1001) begin bad++; $display("FAIL post_reset_press got=%b exp=1001", bus.btn_press); end
    total++; if (bus.btn_toggle !== 4'b1001) begin bad++; $display("FAIL post_reset_toggle got=%b exp=1001", bus.btn_toggle); end
    bus.btn_in = 4'b0000;
    tick(14);
  endtask

  task automatic test_repeat;
    int   press_err;
    int   rel_err;
    int   pulses;
    int   exp_pulses;
    logic exp_p;
    press_err = 0;
    rel_err   = 0;
    pulses    = 0;
    bus.btn_in[0] = 1'b1;
    tick(11);
    total++; if (bus.btn_press[0] !== 1'b1) begin bad++; $display("FAIL repeat_genuine got=%b exp=1", bus.btn_press[0]); end
    for (int rel = 1; rel <= 100; rel++) begin
      @(negedge clk);
`ifdef BTN_REPEAT_EN
      exp_p = (rel >= 40 && rel <= 80 && (rel % 10) == 0);
`else
      exp_p = 1'b0;
`endif
      if (bus.btn_press[0] === 1'b1) pulses++;
      if (bus.btn_press[0] !== exp_p) press_err++;
      if (bus.btn_release[0] !== (rel == 82)) rel_err++;
      if (rel == 71) bus.btn_in[0] = 1'b0;
    end
`ifdef BTN_REPEAT_EN
    exp_pulses = 5;
`else
    exp_pulses = 0;
`endif
    total++; if (press_err !== 0) begin bad++; $display("FAIL repeat_timing got=%0d wrong cycles exp=0", press_err); end
    total++; if (pulses !== exp_pulses) begin bad++; $display("FAIL repeat_count got=%0d exp=%0d", pulses, exp_pulses); end
    total++; if (rel_err !== 0) begin bad++; $display("FAIL repeat_release got=%0d wrong cycles exp=0", rel_err); end
    total++; if (bus.btn_toggle !== 4'b1000) begin bad++; $display("FAIL repeat_toggle got=%b exp=1000", bus.btn_toggle); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.btn_in = 4'b0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_settle();
    test_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
